// File: rtl/pll_cfg_seq.sv
// rtl/pll_cfg_seq.sv - PLL reconfiguration sequencer driving the Avalon-MM management port
// Optional feature macro: PLL_CFG_RETRY_EN (one full-sequence retry after the first timeout)
module pll_cfg_seq #(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cfg_req,
   input  logic [4:0]  cfg_c_idx,
   input  logic [7:0]  cfg_hi,
   input  logic [7:0]  cfg_lo,
   input  logic        cfg_odd,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [5:0]  mgmt_address,
   output logic        mgmt_read,
   output logic        mgmt_write,
   output logic [31:0] mgmt_writedata,
   input  logic [31:0] mgmt_readdata,
   input  logic        mgmt_waitrequest,
   input  logic        pll_locked
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_MODE, S_WR_C, S_WR_START, S_RD_STATUS, S_WAIT_LOCK, S_DONE, S_ERR
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] tmo_cnt;
   logic [4:0]  c_idx_q;
   logic [7:0]  hi_q, lo_q;
   logic        odd_q;
   logic        xfer_done, tmo_hit;
   logic        wr_nxt, rd_nxt;
   logic [5:0]  addr_nxt;
   logic [31:0] data_nxt;
   logic        unused_rd;

   // only the done flag of STATUS matters
   assign unused_rd = ^mgmt_readdata[31:1];

`ifdef PLL_CFG_RETRY_EN
   logic retry_used, retry_set;
`endif

   assign xfer_done = (mgmt_read | mgmt_write) & ~mgmt_waitrequest;
   assign tmo_hit   = (tmo_cnt == TMO_LAST);

   // next-state decode and registered bus command for the state being entered
   always_comb begin
      state_nxt = state;
`ifdef PLL_CFG_RETRY_EN
      retry_set = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (cfg_req) begin
               if (cfg_hi == 8'd0 || cfg_lo == 8'd0 || cfg_c_idx > 5'd17)
                  state_nxt = S_ERR;
               else
                  state_nxt = S_WR_MODE;
            end
         end
         S_WR_MODE:  if (xfer_done) state_nxt = S_WR_C;
         S_WR_C:     if (xfer_done) state_nxt = S_WR_START;
         S_WR_START: if (xfer_done) state_nxt = S_RD_STATUS;
         S_RD_STATUS, S_WAIT_LOCK: begin
            if ((state == S_RD_STATUS) ? (xfer_done && mgmt_readdata[0]) : pll_locked)
               state_nxt = (state == S_RD_STATUS) ? S_WAIT_LOCK : S_DONE;
            else if (tmo_hit) begin
`ifdef PLL_CFG_RETRY_EN
               if (!retry_used) begin
                  state_nxt = S_WR_MODE;
                  retry_set = 1'b1;
               end else begin
                  state_nxt = S_ERR;
               end
`else
               state_nxt = S_ERR;
`endif
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      wr_nxt   = 1'b0;
      rd_nxt   = 1'b0;
      addr_nxt = 6'h00;
      data_nxt = 32'h0;
      case (state_nxt)
         S_WR_MODE:   begin wr_nxt = 1'b1; addr_nxt = 6'h00; data_nxt = 32'h1; end
         S_WR_C:      begin
            wr_nxt   = 1'b1;
            addr_nxt = 6'h05;
            data_nxt = {9'b0, c_idx_q, odd_q, 1'b0, hi_q, lo_q};
         end
         S_WR_START:  begin wr_nxt = 1'b1; addr_nxt = 6'h02; data_nxt = 32'h1; end
         S_RD_STATUS: begin rd_nxt = 1'b1; addr_nxt = 6'h01; end
         default:     ;
      endcase
   end

   // state, bus command registers and timeout counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         tmo_cnt        <= 16'd0;
         mgmt_read      <= 1'b0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= 6'h00;
         mgmt_writedata <= 32'h0;
      end else begin
         state          <= state_nxt;
         mgmt_read      <= rd_nxt;
         mgmt_write     <= wr_nxt;
         mgmt_address   <= addr_nxt;
         mgmt_writedata <= data_nxt;
         if (state_nxt != state)
            tmo_cnt <= 16'd0;
         else if (state == S_RD_STATUS || state == S_WAIT_LOCK)
            tmo_cnt <= tmo_cnt + 16'd1;
      end
   end

   // request fields are captured only when a request is sampled in IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_idx_q <= 5'd0;
         hi_q    <= 8'd0;
         lo_q    <= 8'd0;
         odd_q   <= 1'b0;
      end else if (state == S_IDLE && cfg_req) begin
         c_idx_q <= cfg_c_idx;
         hi_q    <= cfg_hi;
         lo_q    <= cfg_lo;
         odd_q   <= cfg_odd;
      end
   end

`ifdef PLL_CFG_RETRY_EN
   // one retry per request; re-armed whenever the sequencer is idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         retry_used <= 1'b0;
      else if (state == S_IDLE)
         retry_used <= 1'b0;
      else if (retry_set)
         retry_used <= 1'b1;
   end
`endif

   assign cfg_busy = (state == S_WR_MODE) || (state == S_WR_C) || (state == S_WR_START) ||
                     (state == S_RD_STATUS) || (state == S_WAIT_LOCK);
   assign cfg_done = (state == S_DONE);
   assign cfg_err  = (state == S_ERR);

endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb/tb_pll_cfg_seq.sv - self-checking bench for pll_cfg_seq
module tb_pll_cfg_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cfg_req;
   logic [4:0]  cfg_c_idx;
   logic [7:0]  cfg_hi, cfg_lo;
   logic        cfg_odd;
   logic        cfg_busy, cfg_done, cfg_err;
   logic [5:0]  mgmt_address;
   logic        mgmt_read, mgmt_write;
   logic [31:0] mgmt_writedata;
   logic [31:0] mgmt_readdata;
   logic        mgmt_waitrequest;
   logic        pll_locked;

   pll_cfg_seq #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_req(cfg_req), .cfg_c_idx(cfg_c_idx),
      .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_odd(cfg_odd), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .cfg_err(cfg_err), .mgmt_address(mgmt_address),
      .mgmt_read(mgmt_read), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
      .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
      .pll_locked(pll_locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  idx;
      logic [7:0]  hi;
      logic [7:0]  lo;
      logic        odd;
      int          nstall;
      int          nzero;
      bit          ok;
      int          lat;
      logic [31:0] cword;
   } vec_t;

   int n_chk = 0;
   int n_pass = 0;

   int nstall = 0;
   int nzero = 0;
   int n_reads = 0;
   int stall_viol = 0;
   int overlap = 0;
   logic [5:0]  wr_addr[$];
   logic [31:0] wr_data[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   // Avalon slave model: stalls each access nstall cycles, STATUS done after nzero reads
   initial begin
      int acc;
      logic h_rd, h_wr;
      logic [5:0] h_a;
      logic [31:0] h_d;
      acc = 0;
      h_rd = 0; h_wr = 0; h_a = 0; h_d = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            acc = 0;
            mgmt_waitrequest = 1'b0;
         end else if (mgmt_read || mgmt_write) begin
            if (mgmt_read && mgmt_write) overlap++;
            if (acc > 0 && (mgmt_read !== h_rd || mgmt_write !== h_wr ||
                            mgmt_address !== h_a || mgmt_writedata !== h_d))
               stall_viol++;
            h_rd = mgmt_read; h_wr = mgmt_write; h_a = mgmt_address; h_d = mgmt_writedata;
            if (acc < nstall) begin
               mgmt_waitrequest = 1'b1;
               acc++;
            end else begin
               mgmt_waitrequest = 1'b0;
               acc = 0;
               if (mgmt_write) begin
                  wr_addr.push_back(mgmt_address);
                  wr_data.push_back(mgmt_writedata);
               end else begin
                  mgmt_readdata = (n_reads < nzero) ? 32'hABCD_0000 : 32'hABCD_0001;
                  n_reads++;
               end
            end
         end else begin
            acc = 0;
            mgmt_waitrequest = 1'b0;
         end
      end
   end

   task automatic start_req(input vec_t v);
      nstall = v.nstall;
      nzero = v.nzero;
      n_reads = 0;
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      cfg_c_idx = v.idx; cfg_hi = v.hi; cfg_lo = v.lo; cfg_odd = v.odd;
      cfg_req = 1'b1;
      @(posedge clk);
      #1 cfg_req = 1'b0;
   endtask

   // one request; latency counted in cycles from the sampling edge, busy checked each cycle
   task automatic run_req(input vec_t v, output int lat, output bit got_ok, output bit busy_bad);
      start_req(v);
      lat = -1;
      got_ok = 0;
      busy_bad = 0;
      for (int c = 1; c <= 300 && lat < 0; c++) begin
         @(negedge clk);
         if (cfg_done || cfg_err) begin
            lat = c;
            got_ok = cfg_done;
            if (cfg_busy) busy_bad = 1;
         end else if (cfg_busy !== v.ok) begin
            busy_bad = 1;
         end
      end
   endtask

   vec_t vecs[8];
   vec_t v;
   int lat, nd, ne;
   bit got_ok, busy_bad, seq_ok;

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{idx: 5'd1,  hi: 8'h07, lo: 8'h07, odd: 1'b0, nstall: 0, nzero: 0, ok: 1, lat: 6,  cword: 32'h0004_0707};
      vecs[1] = '{idx: 5'd1,  hi: 8'h07, lo: 8'h07, odd: 1'b0, nstall: 3, nzero: 0, ok: 1, lat: 18, cword: 32'h0004_0707};
      vecs[2] = '{idx: 5'd1,  hi: 8'h07, lo: 8'h07, odd: 1'b0, nstall: 0, nzero: 5, ok: 1, lat: 11, cword: 32'h0004_0707};
      vecs[3] = '{idx: 5'd17, hi: 8'h12, lo: 8'h34, odd: 1'b1, nstall: 0, nzero: 0, ok: 1, lat: 6,  cword: 32'h0046_1234};
      vecs[4] = '{idx: 5'd5,  hi: 8'hFF, lo: 8'h01, odd: 1'b0, nstall: 1, nzero: 2, ok: 1, lat: 14, cword: 32'h0014_FF01};
      vecs[5] = '{idx: 5'd1,  hi: 8'h00, lo: 8'h07, odd: 1'b0, nstall: 0, nzero: 0, ok: 0, lat: 1,  cword: 32'h0};
      vecs[6] = '{idx: 5'd1,  hi: 8'h07, lo: 8'h00, odd: 1'b0, nstall: 0, nzero: 0, ok: 0, lat: 1,  cword: 32'h0};
      vecs[7] = '{idx: 5'd18, hi: 8'h07, lo: 8'h07, odd: 1'b0, nstall: 0, nzero: 0, ok: 0, lat: 1,  cword: 32'h0};

      reset_n = 1'b0;
      cfg_req = 1'b0; cfg_c_idx = 0; cfg_hi = 0; cfg_lo = 0; cfg_odd = 0;
      mgmt_readdata = 32'h0; mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_status", {cfg_busy, cfg_done, cfg_err, mgmt_read, mgmt_write}, 0);
      chk("reset_bus", {mgmt_address, mgmt_writedata}, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_req(vecs[i], lat, got_ok, busy_bad);
         chk($sformatf("v%0d_result", i), {got_ok, 32'(lat)}, {vecs[i].ok, 32'(vecs[i].lat)});
         chk($sformatf("v%0d_busy", i), busy_bad, 0);
         chk($sformatf("v%0d_nwrites", i), wr_addr.size(), vecs[i].ok ? 3 : 0);
         chk($sformatf("v%0d_nreads", i), n_reads, vecs[i].ok ? vecs[i].nzero + 1 : 0);
         if (vecs[i].ok) begin
            seq_ok = (wr_addr.size() == 3) && wr_addr[0] == 6'h00 && wr_data[0] == 32'h1 &&
                     wr_addr[1] == 6'h05 && wr_addr[2] == 6'h02 && wr_data[2] == 32'h1;
            chk($sformatf("v%0d_wr_seq", i), seq_ok, 1);
            chk($sformatf("v%0d_c_word", i), (wr_data.size() > 1) ? wr_data[1] : 32'hDEAD_DEAD,
                vecs[i].cword);
         end
      end

      // second request while busy is ignored and does not disturb latched fields
      start_req(vecs[0]);
      nd = 0; ne = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 2) begin
            cfg_c_idx = 5'd3; cfg_hi = 8'h55; cfg_lo = 8'h66; cfg_req = 1'b1;
         end
         if (c == 3) cfg_req = 1'b0;
         if (cfg_done) nd++;
         if (cfg_err) ne++;
      end
      chk("busy_req_done_count", nd, 1);
      chk("busy_req_err_count", ne, 0);
      chk("busy_req_c_word", (wr_data.size() > 1) ? wr_data[1] : 32'hDEAD_DEAD, 32'h0004_0707);
      chk("busy_req_nwrites", wr_addr.size(), 3);

      // timeout: STATUS never reports done
      v = vecs[0];
      v.nzero = 1000;
      run_req(v, lat, got_ok, busy_bad);
`ifdef PLL_CFG_RETRY_EN
      chk("timeout_result", {got_ok, 32'(lat)}, {1'b0, 32'd39});
      chk("timeout_nwrites", wr_addr.size(), 6);
`else
      chk("timeout_result", {got_ok, 32'(lat)}, {1'b0, 32'd20});
      chk("timeout_nwrites", wr_addr.size(), 3);
`endif
      chk("timeout_read_dropped", mgmt_read, 0);
      chk("timeout_busy", busy_bad, 0);
      nd = 0; ne = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (cfg_err) ne++;
         if (cfg_done) nd++;
      end
      chk("timeout_single_err", {nd, ne}, {32'd0, 32'd0});

      // asynchronous reset while polling STATUS
      start_req(v);
      repeat (6) @(negedge clk);
      chk("pre_reset_reading", {mgmt_read, mgmt_address}, {1'b1, 6'h01});
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_status", {cfg_busy, cfg_done, cfg_err, mgmt_read, mgmt_write}, 0);
      chk("async_reset_bus", {mgmt_address, mgmt_writedata}, 0);
      @(negedge clk);
      reset_n = 1'b1;

      run_req(vecs[0], lat, got_ok, busy_bad);
      chk("post_reset_result", {got_ok, 32'(lat)}, {1'b1, 32'd6});

      chk("stall_stability", stall_viol, 0);
      chk("rd_wr_exclusive", overlap, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pll_cfg_seq.md
# pll_cfg_seq

Reconfiguration sequencer for the system PLL: drives the Avalon-MM management port of the PLL reconfiguration controller, whose `reconfig_to_pll` and `reconfig_from_pll` buses connect to the PLL. It accepts a single-counter change request from core logic, for example a CPU-speed selector retuning `outclk_1`. It then issues the mode, C-counter and start writes, polls status until the reconfiguration is done, and waits for PLL lock. It reports completion or timeout with single-cycle pulses.

## Interface
- `TIMEOUT_CYCLES`, default 65535: maximum cycles spent in each of STATUS polling and lock wait before the request is aborted. Range 1..65535.
- `clk` in 1: management clock; all logic is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_req` in 1: request strobe, sampled only in IDLE.
- `cfg_c_idx` in 5: C-counter index, 0..17.
- `cfg_hi` in 8: high count.
- `cfg_lo` in 8: low count.
- `cfg_odd` in 1: odd-division duty-correction enable.
- `cfg_busy` out 1: high from the cycle after acceptance until the cycle of `cfg_done`/`cfg_err`.
- `cfg_done` out 1: one-cycle success pulse.
- `cfg_err` out 1: one-cycle failure pulse (invalid request or timeout).
- `mgmt_address` out 6: Avalon-MM address.
- `mgmt_read` out 1: Avalon-MM read.
- `mgmt_write` out 1: Avalon-MM write.
- `mgmt_writedata` out 32: Avalon-MM write data.
- `mgmt_readdata` in 32: Avalon-MM read data.
- `mgmt_waitrequest` in 1: Avalon-MM stall.
- `pll_locked` in 1: PLL lock. Treated as synchronous to `clk`.

## Operation
- Register map used:
  - 0x00 MODE: write 1 selects polling mode.
  - 0x01 STATUS: read; bit0 = done.
  - 0x02 START: write any value.
  - 0x05 C_COUNTER: write data {9'b0, idx[4:0], odd, bypass=0, hi[7:0], lo[7:0]}, i.e. lo in [7:0], hi in [15:8], bypass in bit 16, odd in bit 17, idx in [22:18].
- Acceptance:
  - In IDLE, `cfg_req`=1 latches `cfg_c_idx`/`cfg_hi`/`cfg_lo`/`cfg_odd` into internal registers.
  - If `cfg_hi`=0, `cfg_lo`=0 or `cfg_c_idx`>17, go to ERR. No bus activity occurs.
  - Otherwise go to WR_MODE.
- `cfg_req` outside IDLE is ignored and is not queued.
- States and transitions:
  - IDLE.
  - WR_MODE → WR_C: write 0x00 ← 1.
  - WR_C → WR_START: write 0x05 ← packed word.
  - WR_START → RD_STATUS: write 0x02 ← 1.
  - RD_STATUS → WAIT_LOCK: read 0x01 completes with bit0=1.
  - RD_STATUS → RD_STATUS: read completes with bit0=0. `mgmt_read` stays high and the next read issues back-to-back.
  - WAIT_LOCK → DONE: `pll_locked`=1.
  - DONE → IDLE.
  - ERR → IDLE.
- Avalon rules:
  - Command, address and data are registered.
  - While `mgmt_waitrequest`=1 they are held stable.
  - A transfer completes in the cycle where the command is high and `mgmt_waitrequest`=0.
  - `mgmt_readdata` is sampled in that same cycle.
  - `mgmt_read` and `mgmt_write` are never high together.
- Timeout:
  - A 16-bit counter clears on entry to RD_STATUS and on entry to WAIT_LOCK, and increments every cycle spent in those states.
  - When it reaches `TIMEOUT_CYCLES`: go to ERR and deassert `mgmt_read` in the next cycle, regardless of `mgmt_waitrequest`.
- DONE/ERR each last one cycle: the corresponding pulse is high there and `cfg_busy` is low.

## Timing
- Reset values: all outputs 0, `mgmt_address`=0, `mgmt_writedata`=0, state IDLE, timeout counter 0.
- Reset is asynchronous: asserting `reset_n` mid-sequence forces reset values immediately, and the bus transaction is abandoned.
- With `mgmt_waitrequest`=0, status done on the first read and `pll_locked`=1, a request at cycle 0 produces:
  - `cfg_busy`=1 at cycle 1.
  - Writes at cycles 1, 2 and 3.
  - Read at cycle 4.
  - WAIT_LOCK at cycle 5.
  - `cfg_done` at cycle 6.
  - Minimum latency is 6 cycles.
- Each `mgmt_waitrequest` stall cycle adds exactly one cycle.
- An invalid request at cycle 0 gives `cfg_err` at cycle 1, and `cfg_busy` is never asserted.
- A new request is accepted the cycle after DONE/ERR.

## Configuration
- `PLL_CFG_RETRY_EN`:
  - Defined: on the first timeout, return to WR_MODE instead of ERR and re-run the full sequence once, with `cfg_busy` held high. A second timeout goes to ERR. The retry flag clears in IDLE.
  - Undefined: the first timeout goes to ERR.
  - Invalid-request rejection is unaffected either way.

## Test plan
- Nominal path: idx=1, hi=7, lo=7, odd=0, no stalls, STATUS=1 → writes 0x00←1, 0x05←0x0004_0707, 0x02←1, then one read of 0x01; `cfg_done` at cycle 6.
- Stall handling: `mgmt_waitrequest` high for 3 cycles on each access → signals held stable throughout each stall; `cfg_done` at cycle 18.
- Polling: STATUS returns 0 for 5 reads, then 1 → 6 back-to-back reads; `cfg_done` at cycle 11.
- Timeout: `TIMEOUT_CYCLES`=16, STATUS always 0 → without the macro, `cfg_err` pulses once and `mgmt_read` deasserts; with `PLL_CFG_RETRY_EN`, the full write sequence repeats once before `cfg_err`.
- Invalid request: hi=0 → `cfg_err` at cycle 1, no `mgmt_*` activity. idx=18 → same response.
- Reset and busy handling: `reset_n` low during RD_STATUS → all outputs 0 immediately. A second `cfg_req` while busy → ignored, exactly one `cfg_done`.
